// File: rtl/data_memory.sv
// ============================================================================
// data_memory : MIPS data-memory stage, byte/half/word loads and stores
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [7:0]  fault_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state;

    logic [31:0]          mem [DEPTH_WORDS];
    logic [ADDR_BITS-1:0] word_idx;
    logic                 accept;
    logic                 op_bad;
    logic                 size_bad;
    logic                 align_bad;
    logic                 range_bad;
    logic                 err;
    logic [3:0]           lane_en;
    logic [31:0]          store_data;
    logic [31:0]          rd_word;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [31:0]          load_value;

    assign word_idx = address[ADDR_BITS+1:2];
    assign accept   = req_valid && (state == IDLE);

    assign op_bad    = (mem_read == mem_write);
    assign size_bad  = (mem_size == 2'b11);
    assign align_bad = ((mem_size == 2'b01) && address[0]) ||
                       ((mem_size == 2'b10) && (address[1:0] != 2'b00));
    assign range_bad = |address[31:ADDR_BITS+2];
    assign err       = op_bad || size_bad || align_bad || range_bad;

    // Store data is replicated across lanes so the lane enables alone pick the target bytes.
    always_comb begin
        lane_en    = 4'b0000;
        store_data = write_data;
        case (mem_size)
            2'b00: begin
                lane_en    = 4'b0001 << address[1:0];
                store_data = {4{write_data[7:0]}};
            end
            2'b01: begin
                lane_en    = address[1] ? 4'b1100 : 4'b0011;
                store_data = {2{write_data[15:0]}};
            end
            2'b10: begin
                lane_en    = 4'b1111;
                store_data = write_data;
            end
            default: begin
                lane_en    = 4'b0000;
                store_data = write_data;
            end
        endcase
    end

    assign rd_word  = mem[word_idx];
    assign byte_sel = rd_word[{address[1:0], 3'b000} +: 8];
    assign half_sel = address[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_value = rd_word;
        case (mem_size)
            2'b00:   load_value = mem_unsigned ? {24'd0, byte_sel}
                                               : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_value = mem_unsigned ? {16'd0, half_sel}
                                               : {{16{half_sel[15]}}, half_sel};
            default: load_value = rd_word;
        endcase
    end

    // Array has no reset; the reset term only blocks an accept while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && accept && !err && mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_data   <= 32'd0;
            resp_err    <= 1'b0;
            fault_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state      <= RESP;
                        req_ready  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                        resp_data  <= (!err && mem_read) ? load_value : 32'd0;
                        if (err && (fault_count != 8'hFF)) begin
                            fault_count <= fault_count + 8'd1;
                        end
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/data_memory.md
# data_memory

Data-memory stage of the single-cycle MIPS datapath, directly downstream of the ALU. It takes the ALU result as a byte address and the second register operand as store data. It performs byte, halfword and word loads and stores through a valid/ready request handshake with a registered response. Illegal accesses are flagged and counted for the debug path.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; must be a power of two.
- ADDR_BITS, 8: log2(DEPTH_WORDS).
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  stage can accept a request.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (second register operand); low bits used for byte/half.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- mem_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- mem_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- resp_valid  out  1  one-cycle response strobe.
- resp_data  out  32  load result; 0 for stores and errors.
- resp_err  out  1  accompanies resp_valid; access was rejected.
- fault_count  out  8  saturating count of rejected accesses.

## Operation
- Storage: DEPTH_WORDS x 32 array, little-endian byte lanes (byte 0 = bits 7:0). Word index = address[ADDR_BITS+1:2]. Contents are not reset.
- FSM states:
  - IDLE: req_ready=1.
  - RESP: req_ready=0, resp_valid=1.
- Transitions:
  - IDLE -> RESP on req_valid (accept).
  - RESP -> IDLE unconditionally. req_valid while in RESP is ignored and not queued.
- On accept, the request is an error if any of the following holds:
  - mem_read and mem_write are both 1, or both are 0.
  - mem_size=11.
  - Halfword with address[0]=1.
  - Word with address[1:0]!=0.
  - address[31:ADDR_BITS+2] is non-zero.
- Error handling: no array write; resp_data=0; resp_err=1; fault_count increments, saturating at 255.
- Valid store: writes only the addressed lanes on the accept edge.
  - Byte: write_data[7:0] into lane address[1:0].
  - Half: write_data[15:0] into lanes {address[1],0} and {address[1],1}.
  - Word: all four lanes.
  - resp_data=0, resp_err=0.
- Valid load: reads the addressed word on the accept edge.
  - Selects the byte or half by address[1:0]; word loads return the full word.
  - Extends to 32 bits per mem_unsigned; mem_unsigned is ignored for word loads.
  - Registers the result into resp_data.

## Timing
- Reset values (asynchronous, immediate): state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, fault_count=0.
- Latency: accept at edge N; resp_valid/resp_data/resp_err are valid during cycle N+1 for exactly one cycle. req_ready is 0 in that cycle.
- Throughput: one request per 2 cycles; back-to-back held req_valid is accepted every other cycle.
- resp_data and resp_err hold their values after resp_valid falls, until the next response.
- A load following a store to the same word returns the new data, since the store committed on an earlier edge.
- Reset asserted during RESP:
  - The response is dropped (resp_valid falls immediately).
  - A store already committed stays in memory.
- Inputs are sampled only on the accept edge; changes during RESP have no effect.

## Test plan
- Store word 0x11223344 at 0x10, then load word 0x10 -> each response arrives one cycle after accept with resp_err=0; load returns resp_data=0x11223344.
- Store byte 0x80 at 0x11, then:
  - load byte signed 0x11 -> 0xFFFFFF80.
  - load byte unsigned 0x11 -> 0x00000080.
  - load word 0x10 -> 0x11228044.
- Store half 0xBEEF at 0x12, then:
  - load half signed 0x12 -> 0xFFFFBEEF.
  - load half unsigned -> 0x0000BEEF.
  - load word 0x10 -> 0xBEEF8044.
- Misaligned and illegal accesses:
  - Load word 0x12 -> resp_err=1, resp_data=0, fault_count=1.
  - Store word 0x11 -> resp_err=1; word 0x10 unchanged.
  - mem_size=11 -> resp_err=1.
  - Address 0x400 with DEPTH_WORDS=256 -> resp_err=1.
  - After these four errors, fault_count=4; 300 errors total saturate it at 255.
- Hold req_valid=1 for 6 cycles with alternating load/store -> exactly 3 accepts; req_ready toggles 1,0,1,0,1,0; no request is accepted while in RESP.
- Assert reset during RESP of a store of 0xCAFEF00D to 0x20 -> resp_valid drops immediately and fault_count=0; after release, load word 0x20 returns 0xCAFEF00D.
